send_fwd: RTL and testbench
===========================

# send_fwd

Producer side of the register-forwarding interface. The block tracks, for the E, M and W pipeline stages, which GPR each in-flight instruction will write, whether it writes at all, and how many cycles remain until its result exists (T_new). It drives the per-stage FWD_{E,M,W}_* bundles that the D-stage forwarding receiver consumes, and raises the D-stage stall when a consumer needs a value sooner than it can be forwarded.

## Interface
Parameters: none.
- clk  in  1  pipeline clock; all state updates on rising edge
- reset  in  1  synchronous, active-low; state clears on a clk edge with reset=0
- D_Reg_Addr  in  5  destination GPR of the instruction in D
- D_Reg_W  in  1  D instruction writes a GPR
- D_T_new  in  3  cycles, counted from entry to E, until the D instruction's result exists (link/lui=0, ALU=1, load=2)
- D_rs, D_rt  in  5  source GPRs read in D
- D_rs_used, D_rt_used  in  1  the D instruction actually reads rs / rt
- D_rs_T_use, D_rt_T_use  in  3  cycles from D until the operand is consumed (branch compare=0, ALU=1, store data=2)
- E_Result, M_Result, W_Result  in  32  data the datapath offers from each stage
- stall  out  1  combinational; freezes PC and the D register, and bubbles E
- FWD_E_Reg_Addr, FWD_M_Reg_Addr, FWD_W_Reg_Addr  out  5  registered stage destination
- FWD_E_Reg_W, FWD_M_Reg_W, FWD_W_Reg_W  out  1  registered stage write enable
- FWD_E_T_new, FWD_M_T_new, FWD_W_T_new  out  3  registered remaining cycles
- FWD_E_Reg_Data, FWD_M_Reg_Data, FWD_W_Reg_Data  out  32  E_Result, M_Result, W_Result passed through combinationally

## Operation
- State: three records {addr[4:0], wen, tnew[2:0]} for E, M and W. Each FWD_x_Reg_Addr, Reg_W and T_new output is the corresponding record field.
- Capture into E (when stall=0): addr=D_Reg_Addr, tnew=D_T_new, wen = D_Reg_W && (D_Reg_Addr != 0).
  - $0 is never advertised as a write, because the receiver does not check for register 0.
- Bubble into E (when stall=1): addr=0, wen=0, tnew=0.
- M is loaded from E, and W from M, every cycle regardless of stall.
  - tnew' = (tnew==0) ? 0 : tnew-1, so the count saturates at 0 and never wraps.
  - addr and wen are copied unchanged.
- Stall terms, evaluated for each source s in {rs, rt}:
  - hitE(s) = s_used && s!=0 && E.wen && E.addr==s && E.tnew > s_T_use
  - hitM(s) = s_used && s!=0 && M.wen && M.addr==s && M.tnew > s_T_use
  - stall = OR of hitE and hitM over rs and rt.
- W never causes a stall. W.tnew is 0 for all legal D_T_new values (0..2).
- D_T_new above 2 is accepted, counts down with saturation, and can cause repeated stalls. It is never truncated.
- A bubble in E clears the E hit on the next cycle. The producer advances to M with its tnew decremented, so a stall sequence always ends.

## Timing
- Reset (reset=0 at an edge): all three records become 0. On the following cycle stall=0 and every FWD_*_Reg_Addr, Reg_W and T_new output is 0.
- Reset has priority over capture and over the bubble.
- Reset asserted mid-stall: stall drops in the cycle after the reset edge.
- Latency: a D instruction appears on the FWD_E outputs 1 cycle after the edge at which stall=0. It appears on FWD_M 2 cycles after that edge and on FWD_W 3 cycles after it.
- stall is a pure function of the current records and the D inputs, with no registered delay.
- The Reg_Data outputs carry no latency.
- Simultaneous hits on rs and rt, or in both E and M, produce a single stall. There is no priority between them.

## Test plan
- Reset: hold reset=0 for 2 cycles with D inputs at random values, then release. Required: all FWD_* addr/W/T_new outputs = 0 and stall=0 on the first cycle after release.
- ALU→ALU: the D instruction writes $8 with T_new=1, is followed by a consumer of rs=$8 with T_use=1, and stall is never asserted. Required: FWD_E shows addr 8, W=1, T_new=1. One cycle later FWD_M shows T_new=0.
- Load-use: a load writing $9 (T_new=2) is followed by a consumer of rs=$9 with T_use=1. Required:
  - stall=1 for exactly 1 cycle;
  - FWD_E shows a bubble (W=0, addr 0, T_new=0) on the next cycle;
  - the load record appears on FWD_M with T_new=1, then on FWD_W with T_new=0.
- Load→branch: a load writing $10 (T_new=2) is followed by a branch reading rt=$10 with T_use=0. Required: stall=1 for exactly 2 consecutive cycles, then 0.
- $0 suppression: D instruction with D_Reg_Addr=0, D_Reg_W=1, T_new=2, followed by a consumer of rs=$0 with T_use=0. Required: FWD_E_Reg_W=0 and stall=0 throughout.
- Unused operand: load writing $11 (T_new=2), followed by an instruction with rt=$11, D_rt_used=0 and rs unrelated. Required: stall=0.

Source files
------------

// File: rtl/send_fwd_if.sv
// Forwarding bundle between the D-stage hazard logic and the send_fwd producer.
// master = send_fwd (drives stall and FWD_*), slave = pipeline side.
interface send_fwd_if;
    logic [4:0]  D_Reg_Addr;
    logic        D_Reg_W;
    logic [2:0]  D_T_new;
    logic [4:0]  D_rs;
    logic [4:0]  D_rt;
    logic        D_rs_used;
    logic        D_rt_used;
    logic [2:0]  D_rs_T_use;
    logic [2:0]  D_rt_T_use;
    logic [31:0] E_Result;
    logic [31:0] M_Result;
    logic [31:0] W_Result;
    logic        stall;
    logic [4:0]  FWD_E_Reg_Addr;
    logic [4:0]  FWD_M_Reg_Addr;
    logic [4:0]  FWD_W_Reg_Addr;
    logic        FWD_E_Reg_W;
    logic        FWD_M_Reg_W;
    logic        FWD_W_Reg_W;
    logic [2:0]  FWD_E_T_new;
    logic [2:0]  FWD_M_T_new;
    logic [2:0]  FWD_W_T_new;
    logic [31:0] FWD_E_Reg_Data;
    logic [31:0] FWD_M_Reg_Data;
    logic [31:0] FWD_W_Reg_Data;

    modport master (
        input  D_Reg_Addr, D_Reg_W, D_T_new,
        input  D_rs, D_rt, D_rs_used, D_rt_used,
        input  D_rs_T_use, D_rt_T_use,
        input  E_Result, M_Result, W_Result,
        output stall,
        output FWD_E_Reg_Addr, FWD_M_Reg_Addr, FWD_W_Reg_Addr,
        output FWD_E_Reg_W, FWD_M_Reg_W, FWD_W_Reg_W,
        output FWD_E_T_new, FWD_M_T_new, FWD_W_T_new,
        output FWD_E_Reg_Data, FWD_M_Reg_Data, FWD_W_Reg_Data
    );

    modport slave (
        output D_Reg_Addr, D_Reg_W, D_T_new,
        output D_rs, D_rt, D_rs_used, D_rt_used,
        output D_rs_T_use, D_rt_T_use,
        output E_Result, M_Result, W_Result,
        input  stall,
        input  FWD_E_Reg_Addr, FWD_M_Reg_Addr, FWD_W_Reg_Addr,
        input  FWD_E_Reg_W, FWD_M_Reg_W, FWD_W_Reg_W,
        input  FWD_E_T_new, FWD_M_T_new, FWD_W_T_new,
        input  FWD_E_Reg_Data, FWD_M_Reg_Data, FWD_W_Reg_Data
    );
endinterface

// File: rtl/send_fwd.sv
// Register-forwarding producer: tracks E/M/W destination records
// and raises the D-stage stall when an operand cannot be forwarded in time.
module send_fwd (
    input  logic              clk,
    input  logic              reset,
    send_fwd_if.master        fwd
);

    typedef struct packed {
        logic [4:0] addr;
        logic       wen;
        logic [2:0] tnew;
    } rec_t;

    rec_t e_q, e_d;
    rec_t m_q, m_d;
    rec_t w_q, w_d;

    logic hit_rs;
    logic hit_rt;
    logic stall;

    // Countdown saturates at 0 so an over-range T_new never wraps.
    function automatic rec_t age(input rec_t r);
        rec_t o;
        o      = r;
        o.tnew = (r.tnew == 3'd0) ? 3'd0 : r.tnew - 3'd1;
        return o;
    endfunction

    function automatic logic hit(
        input rec_t       r,
        input logic [4:0] src,
        input logic       used,
        input logic [2:0] tuse
    );
        return used && (src != 5'd0) && r.wen &&
               (r.addr == src) && (r.tnew > tuse);
    endfunction

    always_comb begin
        hit_rs = hit(e_q, fwd.D_rs, fwd.D_rs_used, fwd.D_rs_T_use) ||
                 hit(m_q, fwd.D_rs, fwd.D_rs_used, fwd.D_rs_T_use);
        hit_rt = hit(e_q, fwd.D_rt, fwd.D_rt_used, fwd.D_rt_T_use) ||
                 hit(m_q, fwd.D_rt, fwd.D_rt_used, fwd.D_rt_T_use);
        stall  = hit_rs || hit_rt;
    end

    always_comb begin
        e_d = '0;
        if (!stall) begin
            e_d.addr = fwd.D_Reg_Addr;
            e_d.wen  = fwd.D_Reg_W && (fwd.D_Reg_Addr != 5'd0);
            e_d.tnew = fwd.D_T_new;
        end
        m_d = age(e_q);
        w_d = age(m_q);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            e_q <= '0;
            m_q <= '0;
            w_q <= '0;
        end else begin
            e_q <= e_d;
            m_q <= m_d;
            w_q <= w_d;
        end
    end

    assign fwd.stall          = stall;
    assign fwd.FWD_E_Reg_Addr = e_q.addr;
    assign fwd.FWD_M_Reg_Addr = m_q.addr;
    assign fwd.FWD_W_Reg_Addr = w_q.addr;
    assign fwd.FWD_E_Reg_W    = e_q.wen;
    assign fwd.FWD_M_Reg_W    = m_q.wen;
    assign fwd.FWD_W_Reg_W    = w_q.wen;
    assign fwd.FWD_E_T_new    = e_q.tnew;
    assign fwd.FWD_M_T_new    = m_q.tnew;
    assign fwd.FWD_W_T_new    = w_q.tnew;
    assign fwd.FWD_E_Reg_Data = fwd.E_Result;
    assign fwd.FWD_M_Reg_Data = fwd.M_Result;
    assign fwd.FWD_W_Reg_Data = fwd.W_Result;

endmodule

// File: tb/tb_send_fwd.sv
// Bench for send_fwd: directed hazard scenarios plus a randomized run
// against a history-based model of the in-flight instructions.
module tb_send_fwd;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    send_fwd_if bus ();

    send_fwd dut (
        .clk   (clk),
        .reset (reset),
        .fwd   (bus)
    );

    int pass_cnt = 0;
    int total    = 0;

    // Model: the last three things that entered E, newest first.
    // Remaining cycles for entry k = entry T_new minus k, floored at 0.
    typedef struct {
        logic [4:0] a;
        logic       w;
        int         t;
    } mrec_t;

    mrec_t hist[3];

    function automatic int sat(input int t, input int k);
        return (t > k) ? t - k : 0;
    endfunction

    function automatic logic m_hit(
        input logic [4:0] s, input logic u, input logic [2:0] tu
    );
        logic h;
        h = 1'b0;
        for (int k = 0; k < 2; k++)
            if (u && s != 0 && hist[k].w && hist[k].a == s &&
                sat(hist[k].t, k) > int'(tu))
                h = 1'b1;
        return h;
    endfunction

    function automatic logic m_stall();
        return m_hit(bus.D_rs, bus.D_rs_used, bus.D_rs_T_use) ||
               m_hit(bus.D_rt, bus.D_rt_used, bus.D_rt_T_use);
    endfunction

    task automatic set_d(
        input logic [4:0] a, input logic w, input logic [2:0] t,
        input logic [4:0] rs, input logic rsu, input logic [2:0] rst,
        input logic [4:0] rt, input logic rtu, input logic [2:0] rtt
    );
        bus.D_Reg_Addr = a;
        bus.D_Reg_W    = w;
        bus.D_T_new    = t;
        bus.D_rs       = rs;
        bus.D_rs_used  = rsu;
        bus.D_rs_T_use = rst;
        bus.D_rt       = rt;
        bus.D_rt_used  = rtu;
        bus.D_rt_T_use = rtt;
        #1;
    endtask

    task automatic idle();
        set_d(5'd0, 1'b0, 3'd0, 5'd0, 1'b0, 3'd0, 5'd0, 1'b0, 3'd0);
    endtask

    task automatic tick();
        logic st;
        st = m_stall();
        if (!reset) begin
            for (int k = 0; k < 3; k++) hist[k] = '{5'd0, 1'b0, 0};
        end else begin
            hist[2] = hist[1];
            hist[1] = hist[0];
            if (st) hist[0] = '{5'd0, 1'b0, 0};
            else hist[0] = '{bus.D_Reg_Addr,
                             bus.D_Reg_W && bus.D_Reg_Addr != 0,
                             int'(bus.D_T_new)};
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            set_d(5'($urandom), 1'b1, 3'($urandom), 5'($urandom),
                  1'b1, 3'($urandom), 5'($urandom), 1'b1,
                  3'($urandom));
            tick();
        end
        reset = 1'b1;
        #1;
        total++;
        if ({bus.FWD_E_Reg_Addr, bus.FWD_E_Reg_W, bus.FWD_E_T_new,
             bus.FWD_M_Reg_Addr, bus.FWD_M_Reg_W, bus.FWD_M_T_new,
             bus.FWD_W_Reg_Addr, bus.FWD_W_Reg_W, bus.FWD_W_T_new}
            !== 27'd0) begin
            $display("FAIL reset_records got E%h/%b/%h M%h/%b/%h W%h/%b/%h want 0",
                     bus.FWD_E_Reg_Addr, bus.FWD_E_Reg_W, bus.FWD_E_T_new,
                     bus.FWD_M_Reg_Addr, bus.FWD_M_Reg_W, bus.FWD_M_T_new,
                     bus.FWD_W_Reg_Addr, bus.FWD_W_Reg_W, bus.FWD_W_T_new);
        end else pass_cnt++;
        total++;
        if (bus.stall !== 1'b0)
            $display("FAIL reset_stall got %b want 0", bus.stall);
        else pass_cnt++;
        idle();
        tick();
    endtask

    task automatic test_alu_alu();
        set_d(5'd8, 1'b1, 3'd1, 5'd0, 1'b0, 3'd0, 5'd0, 1'b0, 3'd0);
        tick();
        set_d(5'd0, 1'b0, 3'd0, 5'd8, 1'b1, 3'd1, 5'd0, 1'b0, 3'd0);
        total++;
        if ({bus.stall, bus.FWD_E_Reg_Addr, bus.FWD_E_Reg_W,
             bus.FWD_E_T_new} !== {1'b0, 5'd8, 1'b1, 3'd1})
            $display("FAIL alu_alu_E got st%b %h/%b/%h want st0 08/1/1",
                     bus.stall, bus.FWD_E_Reg_Addr, bus.FWD_E_Reg_W,
                     bus.FWD_E_T_new);
        else pass_cnt++;
        tick();
        idle();
        total++;
        if ({bus.stall, bus.FWD_M_Reg_Addr, bus.FWD_M_T_new}
            !== {1'b0, 5'd8, 3'd0})
            $display("FAIL alu_alu_M got st%b %h/%h want st0 08/0",
                     bus.stall, bus.FWD_M_Reg_Addr, bus.FWD_M_T_new);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_load_use();
        set_d(5'd9, 1'b1, 3'd2, 5'd0, 1'b0, 3'd0, 5'd0, 1'b0, 3'd0);
        tick();
        set_d(5'd0, 1'b0, 3'd0, 5'd9, 1'b1, 3'd1, 5'd0, 1'b0, 3'd0);
        total++;
        if (bus.stall !== 1'b1)
            $display("FAIL load_use_stall1 got %b want 1", bus.stall);
        else pass_cnt++;
        tick();
        total++;
        if ({bus.stall, bus.FWD_E_Reg_Addr, bus.FWD_E_Reg_W,
             bus.FWD_E_T_new, bus.FWD_M_Reg_Addr, bus.FWD_M_Reg_W,
             bus.FWD_M_T_new}
            !== {1'b0, 5'd0, 1'b0, 3'd0, 5'd9, 1'b1, 3'd1})
            $display("FAIL load_use_bubble got st%b E%h/%b/%h M%h/%b/%h want st0 E00/0/0 M09/1/1",
                     bus.stall, bus.FWD_E_Reg_Addr, bus.FWD_E_Reg_W,
                     bus.FWD_E_T_new, bus.FWD_M_Reg_Addr,
                     bus.FWD_M_Reg_W, bus.FWD_M_T_new);
        else pass_cnt++;
        tick();
        idle();
        total++;
        if ({bus.FWD_W_Reg_Addr, bus.FWD_W_Reg_W, bus.FWD_W_T_new}
            !== {5'd9, 1'b1, 3'd0})
            $display("FAIL load_use_W got %h/%b/%h want 09/1/0",
                     bus.FWD_W_Reg_Addr, bus.FWD_W_Reg_W,
                     bus.FWD_W_T_new);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_load_branch();
        logic [2:0] seen;
        set_d(5'd10, 1'b1, 3'd2, 5'd0, 1'b0, 3'd0, 5'd0, 1'b0, 3'd0);
        tick();
        set_d(5'd0, 1'b0, 3'd0, 5'd0, 1'b0, 3'd0, 5'd10, 1'b1, 3'd0);
        for (int i = 0; i < 3; i++) begin
            seen[2-i] = bus.stall;
            tick();
        end
        total++;
        if (seen !== 3'b110)
            $display("FAIL load_branch_stalls got %b want 110", seen);
        else pass_cnt++;
        idle();
    endtask

    task automatic test_zero_reg();
        logic [2:0] obs;
        set_d(5'd0, 1'b1, 3'd2, 5'd0, 1'b0, 3'd0, 5'd0, 1'b0, 3'd0);
        obs[2] = bus.stall;
        tick();
        set_d(5'd0, 1'b0, 3'd0, 5'd0, 1'b1, 3'd0, 5'd0, 1'b0, 3'd0);
        obs[1] = bus.stall;
        total++;
        if (bus.FWD_E_Reg_W !== 1'b0)
            $display("FAIL zero_reg_wen got %b want 0", bus.FWD_E_Reg_W);
        else pass_cnt++;
        tick();
        obs[0] = bus.stall;
        total++;
        if (obs !== 3'b000)
            $display("FAIL zero_reg_stall got %b want 000", obs);
        else pass_cnt++;
        idle();
        tick();
    endtask

    task automatic test_unused();
        set_d(5'd11, 1'b1, 3'd2, 5'd0, 1'b0, 3'd0, 5'd0, 1'b0, 3'd0);
        tick();
        set_d(5'd0, 1'b0, 3'd0, 5'd3, 1'b1, 3'd1, 5'd11, 1'b0, 3'd0);
        total++;
        if (bus.stall !== 1'b0)
            $display("FAIL unused_rt got %b want 0", bus.stall);
        else pass_cnt++;
        tick();
        idle();
        tick();
    endtask

    task automatic test_reset_mid_stall();
        set_d(5'd12, 1'b1, 3'd2, 5'd0, 1'b0, 3'd0, 5'd0, 1'b0, 3'd0);
        tick();
        set_d(5'd0, 1'b0, 3'd0, 5'd12, 1'b1, 3'd0, 5'd0, 1'b0, 3'd0);
        total++;
        if (bus.stall !== 1'b1)
            $display("FAIL mid_stall_pre got %b want 1", bus.stall);
        else pass_cnt++;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        #1;
        total++;
        if ({bus.stall, bus.FWD_M_Reg_W, bus.FWD_E_Reg_W} !== 3'b000)
            $display("FAIL mid_stall_reset got st%b Mw%b Ew%b want 000",
                     bus.stall, bus.FWD_M_Reg_W, bus.FWD_E_Reg_W);
        else pass_cnt++;
        idle();
        tick();
    endtask

    task automatic test_big_tnew();
        set_d(5'd13, 1'b1, 3'd5, 5'd0, 1'b0, 3'd0, 5'd0, 1'b0, 3'd0);
        tick();
        set_d(5'd0, 1'b0, 3'd0, 5'd13, 1'b1, 3'd0, 5'd0, 1'b0, 3'd0);
        tick();
        total++;
        if ({bus.stall, bus.FWD_M_T_new} !== {1'b1, 3'd4})
            $display("FAIL big_tnew_M got st%b t%h want st1 t4",
                     bus.stall, bus.FWD_M_T_new);
        else pass_cnt++;
        tick();
        total++;
        if ({bus.stall, bus.FWD_W_T_new} !== {1'b0, 3'd3})
            $display("FAIL big_tnew_W got st%b t%h want st0 t3",
                     bus.stall, bus.FWD_W_T_new);
        else pass_cnt++;
        idle();
        tick();
    endtask

    task automatic test_random();
        logic [123:0] got, exp;
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 39) != 0);
            bus.E_Result = $urandom;
            bus.M_Result = $urandom;
            bus.W_Result = $urandom;
            set_d(5'($urandom_range(0, 3)), 1'($urandom),
                  3'($urandom_range(0, 7)),
                  5'($urandom_range(0, 3)), 1'($urandom),
                  3'($urandom_range(0, 2)),
                  5'($urandom_range(0, 3)), 1'($urandom),
                  3'($urandom_range(0, 2)));
            exp = {hist[0].a, hist[0].w, 3'(sat(hist[0].t, 0)),
                   hist[1].a, hist[1].w, 3'(sat(hist[1].t, 1)),
                   hist[2].a, hist[2].w, 3'(sat(hist[2].t, 2)),
                   m_stall(), bus.E_Result, bus.M_Result,
                   bus.W_Result};
            got = {bus.FWD_E_Reg_Addr, bus.FWD_E_Reg_W, bus.FWD_E_T_new,
                   bus.FWD_M_Reg_Addr, bus.FWD_M_Reg_W, bus.FWD_M_T_new,
                   bus.FWD_W_Reg_Addr, bus.FWD_W_Reg_W, bus.FWD_W_T_new,
                   bus.stall, bus.FWD_E_Reg_Data, bus.FWD_M_Reg_Data,
                   bus.FWD_W_Reg_Data};
            total++;
            if (got !== exp)
                $display("FAIL random_%0d got %h want %h", i, got, exp);
            else pass_cnt++;
            tick();
        end
        reset = 1'b1;
    endtask

    initial begin
        for (int k = 0; k < 3; k++) hist[k] = '{5'd0, 1'b0, 0};
        reset = 1'b0;
        bus.E_Result = 32'h0;
        bus.M_Result = 32'h0;
        bus.W_Result = 32'h0;
        idle();
        @(posedge clk);
        #1;
        test_reset();
        test_alu_alu();
        test_load_use();
        test_load_branch();
        test_zero_reg();
        test_unused();
        test_reset_mid_stall();
        test_big_tnew();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
